// File: rtl/irq_sequencer.sv
// irq_sequencer
//
// Machine-mode interrupt sequencer that sits in front of the writeback/CSR
// stage. It latches the three machine interrupt sources into a pending view
// and masks that view with mie and mstatus.MIE. The highest-priority eligible
// request is armed until writeback can commit. At that point the block issues
// a single trap-take pulse carrying the cause and the ISR address. No further
// take is issued until mret retires.
//
// Ports
//   clk          core clock, all state on rising edge
//   rst          synchronous active-low reset
//   sw_irq       software interrupt request (level)
//   timer_irq    timer interrupt request (level)
//   ext_irq      external interrupt request (rising-edge sensitive)
//   mie          mie CSR, bits 11/7/3 used
//   mstatus_mie  global machine interrupt enable
//   mtvec        mtvec CSR (base + mode)
//   wb_valid     writeback holds a valid instruction
//   stall        pipeline stall
//   flush        pipeline flush this cycle
//   mret         mret retiring in writeback
//   irq_take     one-cycle trap-take pulse
//   irq_cause    mcause value, zero unless irq_take
//   irq_vector   ISR address, zero unless irq_take
//   mip          pending view (bits 11/7/3)
//   in_service   trap taken and mret not yet retired
//   fsm_state    sequencer state (debug): 0 IDLE, 1 ARM, 2 SERVICE
//
// Handshake: the trap is taken only in a cycle where an eligible request is
// armed and writeback is committable (wb_valid=1, stall=0, flush=0). That
// cycle is the single cycle in which irq_take is high. There is no
// backpressure beyond that condition, and an armed request waits
// indefinitely for it.

module irq_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sw_irq,
  input  logic            timer_irq,
  input  logic            ext_irq,
  input  logic [XLEN-1:0] mie,
  input  logic            mstatus_mie,
  input  logic [XLEN-1:0] mtvec,
  input  logic            wb_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic            mret,
  output logic            irq_take,
  output logic [XLEN-1:0] irq_cause,
  output logic [XLEN-1:0] irq_vector,
  output logic [XLEN-1:0] mip,
  output logic            in_service,
  output logic [1:0]      fsm_state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  logic [1:0] state;
  logic [1:0] state_nxt;

  logic msip;
  logic mtip;
  logic meip;
  logic ext_prev;

  logic       ext_edge;
  logic       elig_mei;
  logic       elig_msi;
  logic       elig_mti;
  logic       any_elig;
  logic [3:0] code;
  logic       take;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] vec_addr;

  // Only bits 11/7/3 of mie are architecturally meaningful here.
  logic unused_mie;
  assign unused_mie = ^{mie[XLEN-1:12], mie[10:8], mie[6:4], mie[2:0]};

  assign ext_edge = ext_irq & ~ext_prev;

  assign elig_mei = meip & mie[11] & mstatus_mie;
  assign elig_msi = msip & mie[3]  & mstatus_mie;
  assign elig_mti = mtip & mie[7]  & mstatus_mie;
  assign any_elig = elig_mei | elig_msi | elig_mti;

  // Fixed priority MEI > MSI > MTI, re-evaluated every cycle so the cause
  // reflects whatever is highest in the actual take cycle.
  always_comb begin
    code = 4'd0;
    if (elig_mei) begin
      code = CODE_MEI;
    end else if (elig_msi) begin
      code = CODE_MSI;
    end else if (elig_mti) begin
      code = CODE_MTI;
    end
  end

  // Gated by rst so that a reset asserted while armed never lets a take
  // escape in the reset cycle.
  assign take = rst && (state == ARM) && any_elig && wb_valid && !stall && !flush;

  assign base = {mtvec[XLEN-1:2], 2'b00};

  // Vectored mode adds 4*code; the sum wraps modulo 2^XLEN by width.
  always_comb begin
    vec_addr = base;
    if (mtvec[1:0] == 2'b01) begin
      vec_addr = base + {{(XLEN-6){1'b0}}, code, 2'b00};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_elig) state_nxt = ARM;
      end
      ARM: begin
        if (take) begin
          state_nxt = SERVICE;
        end else if (!any_elig) begin
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (mret) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      msip     <= 1'b0;
      mtip     <= 1'b0;
      meip     <= 1'b0;
      ext_prev <= 1'b0;
    end else begin
      state    <= state_nxt;
      msip     <= sw_irq;
      mtip     <= timer_irq;
      ext_prev <= ext_irq;
      // A fresh edge takes precedence over the clear from a cause-11 take.
      if (ext_edge) begin
        meip <= 1'b1;
      end else if (take && (code == CODE_MEI)) begin
        meip <= 1'b0;
      end
    end
  end

  assign irq_take   = take;
  assign irq_cause  = take ? {1'b1, {(XLEN-5){1'b0}}, code} : '0;
  assign irq_vector = take ? vec_addr : '0;

  always_comb begin
    mip     = '0;
    mip[11] = meip;
    mip[7]  = mtip;
    mip[3]  = msip;
  end

  assign in_service = (state == SERVICE);
  assign fsm_state  = state;

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Machine-mode interrupt sequencer between the interrupt sources and the three-stage pipeline's writeback/CSR stage. It latches the software, timer and external requests into a pending view and gates them with `mie`/`mstatus.MIE`. It selects the highest-priority eligible request and waits until the writeback stage holds a committable instruction. It then issues a single trap-take pulse with cause and ISR address, and blocks further takes until `mret` retires.

## Interface
- XLEN, 32, datapath and CSR width
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- sw_irq  in  1  software interrupt, level
- timer_irq  in  1  timer interrupt, level
- ext_irq  in  1  external interrupt, rising-edge sensitive, synchronous to clk
- mie  in  XLEN  current mie CSR; bits 11/7/3 used
- mstatus_mie  in  1  global machine interrupt enable
- mtvec  in  XLEN  current mtvec CSR
- wb_valid  in  1  writeback stage holds a valid instruction
- stall  in  1  pipeline stall
- flush  in  1  pipeline flush this cycle
- mret  in  1  mret retiring in writeback
- irq_take  out  1  one-cycle pulse: pipeline traps this cycle
- irq_cause  out  XLEN  mcause value, valid while irq_take=1
- irq_vector  out  XLEN  ISR address, valid while irq_take=1
- mip  out  XLEN  pending view, only bits 11/7/3 nonzero
- in_service  out  1  high from the cycle after a take until the cycle after mret

## Operation
- Pending register (3 bits):
  - MSIP follows sw_irq, registered.
  - MTIP follows timer_irq, registered.
  - MEIP sets on a rising edge of ext_irq (previous-sample register) and clears on a take with cause 11.
  - A new edge in the same cycle as an MEIP clear wins: MEIP stays 1.
- Eligible = pending & {mie[11], mie[7], mie[3]} & mstatus_mie.
- Priority: MEI (code 11) > MSI (code 3) > MTI (code 7).
- FSM states: IDLE, ARM, SERVICE.
  - IDLE: any eligible → ARM.
  - ARM, take condition (eligible≠0, wb_valid=1, stall=0, flush=0):
    - assert irq_take, irq_cause={1'b1, (XLEN-5)'b0, code}, irq_vector;
    - → SERVICE.
  - ARM, eligible=0 (source dropped or enable cleared): → IDLE, no take.
  - ARM, otherwise: stay.
  - The cause is re-arbitrated every ARM cycle; the value issued is the highest eligible in the take cycle.
  - SERVICE: no takes. mret=1 → IDLE. Pending keeps updating.
  - mret in IDLE or ARM is ignored.
- Vector:
  - base = {mtvec[XLEN-1:2], 2'b00}.
  - mtvec[1:0]==1 (vectored): base + 4*code, modulo 2^XLEN.
  - Otherwise (0, 2, 3): base.
- irq_cause and irq_vector are 0 whenever irq_take=0.

## Timing
- Reset (rst=0 at a clock edge): state IDLE, pending 0, edge register 0. irq_take=0, irq_cause=0, irq_vector=0, mip=0, in_service=0. A reset during ARM or SERVICE aborts immediately, with no take.
- Source to take:
  - Source sampled at edge E, mip visible from cycle E+1.
  - IDLE→ARM at edge E+1; earliest irq_take in cycle E+2 if the pipeline is committable.
- irq_take is combinational from registered state plus wb_valid/stall/flush; outputs settle in the same cycle.
- Exactly one irq_take per SERVICE entry. in_service rises the cycle after the take.
- mret at edge M → IDLE at M+1. A still-pending eligible source reaches ARM at M+2, giving at least one IDLE cycle between services.
- flush or stall in ARM defers the take with no limit; state stays ARM.

## Test plan
- Reset: hold rst=0 for 3 cycles with all sources high → all outputs 0, state IDLE. Release rst → first irq_take no earlier than the 2nd cycle after release.
- Timer, direct mode: mie=0x80, mstatus_mie=1, mtvec=0x100, wb_valid=1, timer_irq=1 → irq_take exactly 2 cycles later, irq_cause=0x80000007, irq_vector=0x100, in_service=1 next cycle.
- Priority, vectored mode: all three sources asserted in the same cycle, mie=0x888, mtvec=0x201 → irq_cause=0x8000000B, irq_vector=0x22C. MEIP clears; mip=0x88 afterwards.
- Defer: ARM with stall=1 for 4 cycles, then flush=1 for 1 cycle → no irq_take. The take occurs on the first cycle with stall=0, flush=0, wb_valid=1.
- Withdraw/enable: in ARM, clear mstatus_mie → return to IDLE, no take. A second ext_irq edge during SERVICE keeps MEIP=1. After mret, the take occurs 2 cycles later with cause 0x8000000B.
- Edge case: ext_irq held high for 10 cycles → one MEIP set only. A re-take after mret requires a new rising edge.
